// File: rtl/ps2_device.sv
// ps2_device: device side of a PS/2 link. Sends bytes to the host on Write,
// accepts host-to-device bytes after a request-to-send, and generates the
// PS/2 clock in both directions. PS2Clk/PS2Data are open-drain (0 or Z).
// Optional build macro: PS2_DEVICE_PARITY_CHECK_EN -- when defined, a host
// byte with wrong odd parity is reported on RxError instead of RxDone.
module ps2_device #(
    parameter int CLK_HALF = 1000,
    parameter int RTS_MIN  = 5000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Write,
    input  logic [7:0] TxData,
    output logic       TxBusy,
    output logic       TxDone,
    output logic       TxAbort,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       RxError,
    inout  wire        PS2Clk,
    inout  wire        PS2Data
);

    localparam int TW = $clog2(2 * CLK_HALF + 1);
    localparam int RW = $clog2(RTS_MIN + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_HALF - 1);
    localparam logic [TW-1:0] SAMPLE_AT = TW'(CLK_HALF / 2);
    localparam logic [TW-1:0] IDLE_MIN  = TW'(2 * CLK_HALF);
    localparam logic [TW-1:0] COOL_LAST = TW'(2 * CLK_HALF - 1);
    // After the device releases PS2Clk the synchronized copy lags by a few
    // cycles; a low seen earlier than this is our own clock, not the host.
    localparam logic [TW-1:0] SETTLE    = TW'(3);
    localparam logic [RW-1:0] RTS_SAT   = RW'(RTS_MIN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TX       = 3'd1;
    localparam logic [2:0] S_RTS_WAIT = 3'd2;
    localparam logic [2:0] S_RX       = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_COOLDOWN = 3'd5;

    logic [2:0]    state;
    logic [TW-1:0] tmr;
    logic [3:0]    bit_cnt;
    logic          phase_hi;
    logic          clk_oe;
    logic          dat_oe;
    logic [9:0]    tx_frame;
    logic [9:0]    rx_shreg;
    logic [TW-1:0] idle_cnt;
    logic [RW-1:0] rts_cnt;
    logic          clk_p0, clk_p1;
    logic          dat_p0, dat_p1;
    logic          bus_idle;

    // Odd parity bit for a data byte: total ones over data+parity is odd.
    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    assign PS2Clk   = clk_oe ? 1'b0 : 1'bz;
    assign PS2Data  = dat_oe ? 1'b0 : 1'bz;
    assign TxBusy   = (state != S_IDLE);
    assign bus_idle = (idle_cnt == IDLE_MIN);

    // Two-flop synchronizers for both PS/2 lines.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= PS2Clk;
            clk_p1 <= clk_p0;
            dat_p0 <= PS2Data;
            dat_p1 <= dat_p0;
        end
    end

    // Line monitors: bus-idle run length and PS2Clk-low run length (saturating).
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            idle_cnt <= '0;
            rts_cnt  <= '0;
        end else begin
            if (clk_p1 && dat_p1) begin
                if (idle_cnt != IDLE_MIN) idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
            if (!clk_p1) begin
                if (rts_cnt != RTS_SAT) rts_cnt <= rts_cnt + RW'(1);
            end else begin
                rts_cnt <= '0;
            end
        end
    end

    // Protocol state machine: clock generation, bit shifting and status pulses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= S_IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            RxData   <= 8'h00;
            TxDone   <= 1'b0;
            TxAbort  <= 1'b0;
            RxDone   <= 1'b0;
            RxError  <= 1'b0;
        end else begin
            TxDone  <= 1'b0;
            TxAbort <= 1'b0;
            RxDone  <= 1'b0;
            RxError <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_oe <= 1'b0;
                    dat_oe <= 1'b0;
                    tmr    <= '0;
                    if (Write && bus_idle) begin
                        // Start bit goes out now; frame holds the remaining bits.
                        tx_frame <= {1'b1, odd_par(TxData), TxData};
                        dat_oe   <= 1'b1;
                        phase_hi <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= S_TX;
                    end else if (clk_p1 && !dat_p1 && (rts_cnt == RTS_SAT)) begin
                        state <= S_RTS_WAIT;
                    end
                end

                S_TX: begin
                    if (phase_hi && (tmr >= SETTLE) && !clk_p1 && (bit_cnt < 4'd9)) begin
                        clk_oe  <= 1'b0;
                        dat_oe  <= 1'b0;
                        TxAbort <= 1'b1;
                        tmr     <= '0;
                        state   <= S_IDLE;
                    end else if (tmr == HALF_LAST) begin
                        tmr <= '0;
                        if (phase_hi) begin
                            phase_hi <= 1'b0;
                            clk_oe   <= 1'b1;
                        end else if (bit_cnt == 4'd10) begin
                            clk_oe <= 1'b0;
                            dat_oe <= 1'b0;
                            TxDone <= 1'b1;
                            state  <= S_COOLDOWN;
                        end else begin
                            phase_hi <= 1'b1;
                            clk_oe   <= 1'b0;
                            dat_oe   <= ~tx_frame[0];
                            tx_frame <= {1'b1, tx_frame[9:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                // The released interval here is the high half of the start
                // bit; RX then opens with that bit's low half.
                S_RTS_WAIT: begin
                    if (tmr == HALF_LAST) begin
                        tmr      <= '0;
                        clk_oe   <= 1'b1;
                        phase_hi <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= S_RX;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                S_RX: begin
                    if (phase_hi && (tmr == SAMPLE_AT)) begin
                        rx_shreg <= {dat_p1, rx_shreg[9:1]};
                    end
                    if (tmr == HALF_LAST) begin
                        tmr <= '0;
                        if (phase_hi) begin
                            phase_hi <= 1'b0;
                            clk_oe   <= 1'b1;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd10) begin
                            phase_hi <= 1'b1;
                            clk_oe   <= 1'b0;
                            dat_oe   <= 1'b1;
                            state    <= S_ACK;
                        end else begin
                            phase_hi <= 1'b1;
                            clk_oe   <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                // rx_shreg: [9] stop, [8] parity, [7:0] data.
                S_ACK: begin
                    if (tmr == HALF_LAST) begin
                        tmr <= '0;
                        if (phase_hi) begin
                            phase_hi <= 1'b0;
                            clk_oe   <= 1'b1;
                        end else begin
                            clk_oe <= 1'b0;
                            dat_oe <= 1'b0;
                            state  <= S_COOLDOWN;
                            if (!rx_shreg[9]) begin
                                RxError <= 1'b1;
`ifdef PS2_DEVICE_PARITY_CHECK_EN
                            end else if (rx_shreg[8] != odd_par(rx_shreg[7:0])) begin
                                RxError <= 1'b1;
`endif
                            end else begin
                                RxData <= rx_shreg[7:0];
                                RxDone <= 1'b1;
                            end
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                S_COOLDOWN: begin
                    clk_oe <= 1'b0;
                    dat_oe <= 1'b0;
                    if (tmr == COOL_LAST) begin
                        tmr   <= '0;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                default: begin
                    clk_oe <= 1'b0;
                    dat_oe <= 1'b0;
                    tmr    <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
